// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the fetch PC, applies EX-stage redirects,
// arbitrates hazard stall and imem backpressure, and drives pipeline flushes.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   stall           hazard unit hold request
//   PcSel, BrPC     branch unit redirect strobe and target
//   imem_ready      imem accepts the fetch at pc_o this cycle
//   pc_o            current fetch PC (Cur_PC to branch unit)
//   fetch_valid     pc_o is a live fetch request
//   flush_ifid/idex squash strobes for the IF/ID and ID/EX registers
//   misalign_err    one-cycle pulse when a redirect target had BrPC[1:0]!=0
//   redirect_cnt    saturating count of accepted redirects
//
// Build option: define REDIRECT_STATS_EN to implement redirect_cnt;
// otherwise it is tied to zero.
//
// A redirect loads pc_o with the target on the edge it is sampled, so the
// target itself is the pending PC while waiting in HOLD.
// fetch_valid is registered: in RUN it drops for the cycles following an
// edge at which a stall held the PC.
module fetch_pc_sequencer #(
  parameter int              PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            imem_ready,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_valid,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misalign_err,
  output logic [15:0]     redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH,
    HOLD
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYC - 1);

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_d;
  logic [2:0]      cnt_q;
  logic [2:0]      cnt_d;
  logic            redirect;
  logic            run_stalled;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  logic            unused_brpc;

  assign target      = {BrPC[PC_W-1:2], 2'b00};
  assign pc_inc      = pc_o + PC_W'(4);
  assign unused_brpc = ^BrPC[31:PC_W];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_o;
    cnt_d       = cnt_q;
    redirect    = 1'b0;
    run_stalled = 1'b0;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (PcSel) begin
      redirect = 1'b1;
      pc_d     = target;
      cnt_d    = CNT_LOAD;
      state_d  = imem_ready ? FLUSH : HOLD;
    end else if (stall) begin
      run_stalled = (state_q == RUN);
    end else begin
      unique case (state_q)
        RUN: begin
          if (imem_ready) pc_d = pc_inc;
        end
        FLUSH: begin
          if (imem_ready) pc_d = pc_inc;
          if (cnt_q == 3'd0) state_d = RUN;
          else cnt_d = cnt_q - 3'd1;
        end
        HOLD: begin
          if (imem_ready) begin
            pc_d    = pc_inc;
            cnt_d   = CNT_LOAD;
            state_d = FLUSH;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_o         <= RESET_PC;
      cnt_q        <= '0;
      fetch_valid  <= 1'b0;
      flush_ifid   <= 1'b0;
      flush_idex   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_o         <= pc_d;
      cnt_q        <= cnt_d;
      fetch_valid  <= (state_d != BOOT) && !run_stalled;
      flush_ifid   <= (state_d == FLUSH) || (state_d == HOLD);
      flush_idex   <= (state_d == FLUSH) || (state_d == HOLD);
      misalign_err <= redirect && (BrPC[1:0] != 2'b00);
    end
  end

`ifdef REDIRECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
    end else if (redirect && (redirect_cnt != 16'hFFFF)) begin
      redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`else
  assign redirect_cnt = 16'h0;
`endif

endmodule
